// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : fetch PC, in-order imem request channel, {pc,inst} FIFO,
//                    redirect flush with drain of in-flight responses.
// Optional macro   : FETCH_ALIGN_CHECK_EN (misaligned-redirect fault + HALT)
// Revision         : 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter int unsigned       PC_STEP    = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_fault
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
    , S_HALT = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [PTR_W-1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [ADDR_W-1:0] tag_q       [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic has_credit, req_fire, rsp_fire, push, pop, halted, halt_req, redir;

  assign has_credit     = ({1'b0, fifo_cnt_q} + {1'b0, outstanding_q}) < DEPTH_C;
  assign imem_req_valid = (state_q == S_FETCH) && has_credit;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (outstanding_q != '0);

  assign inst_valid = (fifo_cnt_q != '0);
  assign inst_data  = inst_valid ? fifo_data_q[fifo_rd_q] : '0;
  assign inst_pc    = inst_valid ? fifo_pc_q[fifo_rd_q]   : '0;
  assign pop        = inst_valid && inst_ready;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign halted      = (state_q == S_HALT);
  assign halt_req    = redirect_valid && !halted && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else if (halt_req) fault_q <= 1'b1;
  end
`else
  assign halted      = 1'b0;
  assign halt_req    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign redir = redirect_valid && !halted;
  // Only responses landing in FETCH with no redirect are real; stale ones just retire a credit.
  assign push  = rsp_fire && (state_q == S_FETCH) && !redir;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    fifo_rd_d     = fifo_rd_q + PTR_W'(pop);
    fifo_wr_d     = fifo_wr_q + PTR_W'(push);
    tag_rd_d      = tag_rd_q + PTR_W'(push);
    tag_wr_d      = tag_wr_q + PTR_W'(req_fire);

    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);

    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      S_DRAIN: if (outstanding_d == '0) state_d = S_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
      S_HALT:  state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase

    if (redir) begin
      fetch_pc_d = redirect_pc;
      fifo_cnt_d = '0;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      state_d    = (outstanding_d != '0) ? S_DRAIN : S_FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
      if (halt_req) state_d = S_HALT;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      fifo_cnt_q    <= '0;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      fifo_cnt_q    <= fifo_cnt_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (req_fire && !redir) tag_q[tag_wr_q] <= fetch_pc_q;
    if (push) begin
      fifo_pc_q[fifo_wr_q]   <= tag_q[tag_rd_q];
      fifo_data_q[fifo_wr_q] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit: directed and randomized fetch/redirect traffic checked
// against a sequential-PC reference model with an in-order memory model.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .PC_STEP(4)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Reference model: delivered and requested PCs are each a plain +4 sequence
  // restarted at every redirect; memory returns in order after a random delay.
  logic [31:0] exp_pc, exp_req, prev_pc;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0, since_reset = 0, last_due = 0;
  int          lat_min = 1, lat_max = 1;
  int          req_cnt = 0, dlv_cnt = 0, first_valid = -1;
  bit          tb_drain = 0, tb_halt = 0, prev_hold = 0, drain_seen = 0, wrap_seen = 0;
  bit          inject_stale = 0, combo_mode = 0, combo_done = 0;
  logic        d_req_ready = 0, d_inst_ready = 0, d_redirect = 0;
  logic [31:0] d_redirect_pc = '0;

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr",  imem_req_addr, RESET_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc",   inst_pc, 32'd0);
    check("rst_fault",     32'(fetch_fault), 32'd0);
    mq_addr.delete();
    mq_due.delete();
    exp_pc = RESET_PC;  exp_req = RESET_PC;
    tb_drain = 0;  tb_halt = 0;  prev_hold = 0;
    since_reset = 0;  first_valid = -1;  last_due = 0;
    d_redirect = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic tick();
    bit rsp, req_hs, inst_hs;
    int due;
    @(negedge clk);
    cyc++;
    since_reset++;
    rsp = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq_addr[0]) : $urandom;
    if (inject_stale && !rsp) imem_rsp_valid = 1'b1;
    inject_stale   = 0;
    imem_req_ready = d_req_ready;
    inst_ready     = d_inst_ready;
    redirect_valid = d_redirect;
    redirect_pc    = d_redirect_pc;
    #1;
    if (combo_mode) begin
      if (inst_valid && inst_pc == 32'h8 && imem_req_valid) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        inst_ready     = 1'b1;
        imem_req_ready = 1'b1;
        combo_mode     = 0;
        combo_done     = 1;
      end else if (imem_req_valid && imem_req_addr == 32'hC) begin
        imem_req_ready = 1'b0;
      end
      #1;
    end

    if (tb_drain || tb_halt) begin
      check("quiet_req_valid", 32'(imem_req_valid), 32'd0);
      check("quiet_inst_valid", 32'(inst_valid), 32'd0);
    end
    if (prev_hold) begin
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_pc", inst_pc, prev_pc);
    end
`ifdef FETCH_ALIGN_CHECK_EN
    check("fault", 32'(fetch_fault), 32'(tb_halt));
`else
    check("fault", 32'(fetch_fault), 32'd0);
`endif
    if (inst_valid && first_valid < 0) first_valid = since_reset;

    inst_hs = inst_valid && inst_ready;
    req_hs  = imem_req_valid && imem_req_ready;
    if (inst_hs) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_data", inst_data, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      dlv_cnt++;
    end
    if (req_hs) begin
      check("req_addr", imem_req_addr, exp_req);
      if (imem_req_addr == 32'h0 && exp_req == 32'h0 && since_reset > 4) wrap_seen = 1;
      exp_req = exp_req + 32'd4;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(due);
      req_cnt++;
      check("credit_cap", 32'(mq_addr.size()), (mq_addr.size() <= DEPTH) ? 32'(mq_addr.size()) : 32'(DEPTH));
    end
    if (rsp) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (redirect_valid && !tb_halt) begin
      exp_pc  = redirect_pc;
      exp_req = redirect_pc;
      tb_drain = (mq_addr.size() > 0);
      if (tb_drain) drain_seen = 1;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        tb_halt  = 1;
        tb_drain = 0;
      end
`endif
    end else if (tb_drain && mq_addr.size() == 0) begin
      tb_drain = 0;
    end
    prev_hold = inst_valid && !inst_ready && !redirect_valid;
    prev_pc   = inst_pc;
  endtask

  initial begin
    int cnt0, guard;
    logic [31:0] t;

    // Cold start, 1-cycle memory, decode always ready, stale response in first cycle.
    do_reset();
    d_req_ready = 1;  d_inst_ready = 1;  lat_min = 1;  lat_max = 1;
    inject_stale = 1;
    dlv_cnt = 0;
    repeat (12) tick();
    check("first_valid_cycle", 32'(first_valid), 32'd3);
    check("cold_deliveries", 32'(dlv_cnt >= 5), 32'd1);

    // Decode stalled: only DEPTH requests go out, then ordered delivery.
    do_reset();
    d_inst_ready = 0;  req_cnt = 0;  dlv_cnt = 0;
    repeat (10) tick();
    check("stall_req_cnt", 32'(req_cnt), 32'd2);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_inst_valid", 32'(inst_valid), 32'd1);
    check("stall_head_pc", inst_pc, 32'h0);
    d_inst_ready = 1;
    repeat (6) tick();
    check("stall_release", 32'(dlv_cnt >= 2), 32'd1);

    // Redirect with two requests in flight on a 3-cycle memory.
    do_reset();
    lat_min = 3;  lat_max = 3;  drain_seen = 0;
    guard = 0;
    while (mq_addr.size() < 2 && guard < 20) begin tick(); guard++; end
    check("outstanding_reached", 32'(mq_addr.size()), 32'd2);
    d_redirect = 1;  d_redirect_pc = 32'h100;
    tick();
    d_redirect = 0;
    dlv_cnt = 0;
    repeat (20) tick();
    check("drain_entered", 32'(drain_seen), 32'd1);
    check("redirect_delivers", 32'(dlv_cnt >= 2), 32'd1);

    // Redirect coinciding with inst handshake of 0x8 and request handshake of 0xC.
    do_reset();
    lat_min = 1;  lat_max = 1;  combo_done = 0;  combo_mode = 1;
    guard = 0;
    while (!combo_done && guard < 30) begin tick(); guard++; end
    combo_mode = 0;
    check("combo_hit", 32'(combo_done), 32'd1);
    dlv_cnt = 0;
    repeat (12) tick();
    check("combo_delivers", 32'(dlv_cnt >= 2), 32'd1);

    // Address wrap, then asynchronous reset mid-burst.
    wrap_seen = 0;
    d_redirect = 1;  d_redirect_pc = 32'hFFFF_FFF8;
    tick();
    d_redirect = 0;
    repeat (12) tick();
    check("wrap_seen", 32'(wrap_seen), 32'd1);
    do_reset();
    dlv_cnt = 0;
    repeat (8) tick();
    check("restart_delivers", 32'(dlv_cnt >= 2), 32'd1);

    // Misaligned redirect target.
    d_redirect = 1;  d_redirect_pc = 32'h102;
    tick();
    d_redirect = 0;
    req_cnt = 0;  dlv_cnt = 0;
    repeat (15) tick();
`ifdef FETCH_ALIGN_CHECK_EN
    check("halt_fault", 32'(fetch_fault), 32'd1);
    check("halt_no_req", 32'(req_cnt), 32'd0);
    check("halt_no_inst", 32'(dlv_cnt), 32'd0);
`else
    check("misalign_fault", 32'(fetch_fault), 32'd0);
    check("misalign_fetches", 32'(req_cnt > 0), 32'd1);
    check("misalign_delivers", 32'(dlv_cnt > 0), 32'd1);
`endif

    // Randomized traffic.
    do_reset();
    lat_min = 1;  lat_max = 4;  dlv_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      d_req_ready  = ($urandom_range(3, 0) != 0);
      d_inst_ready = ($urandom_range(3, 0) != 0);
      d_redirect   = ($urandom_range(15, 0) == 0);
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
      d_redirect_pc = t;
      tick();
    end
    d_redirect = 0;
    cnt0 = dlv_cnt;
    check("random_progress", 32'(cnt0 > 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
